// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and hysteretic pause.
// Latency: FWFT=0 pop data one cycle after an accepted read; FWFT=1 head word visible combinationally.
// Backpressure: fifo_pause sets at count >= afull_thr and releases at count <= aempty_thr; rejected ops set fifo_error.
//
// Ports:
//   clk, reset (async active-low)     clock and reset
//   write / read / data_in_push       push and pop requests, push data
//   afull_thr / aempty_thr            occupancy thresholds, sampled every cycle
//   err_clr                           clears the sticky error (a fault on the same edge wins)
//   data_out_pop / valid_out          popped word (FWFT=1: head word) and its qualifier
//   fifo_count, Fifo_full, fifo_empty, almost_full, almost_empty, fifo_pause, fifo_error
module fifo_flow_ctrl #(
    parameter int DATA_SIZE = 10,
    parameter int MAIN_SIZE = 8,
    parameter int FWFT      = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write,
    input  logic                         read,
    input  logic [DATA_SIZE-1:0]         data_in_push,
    input  logic [$clog2(MAIN_SIZE):0]   afull_thr,
    input  logic [$clog2(MAIN_SIZE):0]   aempty_thr,
    input  logic                         err_clr,
    output logic [DATA_SIZE-1:0]         data_out_pop,
    output logic                         valid_out,
    output logic [$clog2(MAIN_SIZE):0]   fifo_count,
    output logic                         Fifo_full,
    output logic                         fifo_empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         fifo_pause,
    output logic                         fifo_error
);

    localparam int ADDR_W = $clog2(MAIN_SIZE);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_SIZE-1:0] mem [MAIN_SIZE];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]     count_nxt;
    logic                 pop_acc;
    logic                 push_acc;
    logic                 fault;

    // Flags decode the count register only, keeping read/write off these paths.
    assign Fifo_full    = (fifo_count == CNT_W'(MAIN_SIZE));
    assign fifo_empty   = (fifo_count == '0);
    assign almost_full  = (fifo_count >= afull_thr);
    assign almost_empty = (fifo_count <= aempty_thr);

    // A full FIFO still takes a push when a pop frees the slot on the same edge.
    assign pop_acc  = read && !fifo_empty;
    assign push_acc = write && (!Fifo_full || pop_acc);
    assign fault    = (write && !push_acc) || (read && !pop_acc);

    always_comb begin
        count_nxt = fifo_count;
        case ({push_acc, pop_acc})
            2'b10:   count_nxt = fifo_count + CNT_W'(1);
            2'b01:   count_nxt = fifo_count - CNT_W'(1);
            default: count_nxt = fifo_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_pause <= 1'b0;
            fifo_error <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + ADDR_W'(1);
            fifo_count <= count_nxt;
            // Hysteresis: hold between the two thresholds.
            if (count_nxt >= afull_thr)
                fifo_pause <= 1'b1;
            else if (count_nxt <= aempty_thr)
                fifo_pause <= 1'b0;
            if (fault)
                fifo_error <= 1'b1;
            else if (err_clr)
                fifo_error <= 1'b0;
        end
    end

    // Storage is not reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr] <= data_in_push;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out_pop = mem[rd_ptr];
            assign valid_out    = !fifo_empty;
        end else begin : g_reg
            // Full + read + write: the read sees the old head because the
            // overwrite of that slot lands on the same edge.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_out_pop <= '0;
                    valid_out    <= 1'b0;
                end else begin
                    valid_out <= pop_acc;
                    if (pop_acc) data_out_pop <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
module tb_fifo_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] afull_thr = 4'd6;
    logic [3:0] aempty_thr = 4'd2;
    logic       err_clr = 1'b0;

    // Registered-read instance
    logic       write0 = 1'b0, read0 = 1'b0;
    logic [9:0] din0 = '0, dout0;
    logic       valid0, full0, empty0, af0, ae0, pause0, err0;
    logic [3:0] count0;

    // FWFT instance
    logic       write1 = 1'b0, read1 = 1'b0;
    logic [9:0] din1 = '0, dout1;
    logic       valid1, full1, empty1, af1, ae1, pause1, err1;
    logic [3:0] count1;

    int total = 0;
    int bad = 0;
    logic [9:0] mdl[$];     // words the FIFO should currently hold
    logic [9:0] exp_q[$];   // words expected on data_out_pop, in order

    always #5 clk = ~clk;

    fifo_flow_ctrl #(.DATA_SIZE(10), .MAIN_SIZE(8), .FWFT(0)) d0 (
        .clk(clk), .reset(reset), .write(write0), .read(read0), .data_in_push(din0),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .err_clr(err_clr),
        .data_out_pop(dout0), .valid_out(valid0), .fifo_count(count0), .Fifo_full(full0),
        .fifo_empty(empty0), .almost_full(af0), .almost_empty(ae0), .fifo_pause(pause0),
        .fifo_error(err0));

    fifo_flow_ctrl #(.DATA_SIZE(10), .MAIN_SIZE(8), .FWFT(1)) d1 (
        .clk(clk), .reset(reset), .write(write1), .read(read1), .data_in_push(din1),
        .afull_thr(afull_thr), .aempty_thr(aempty_thr), .err_clr(1'b0),
        .data_out_pop(dout1), .valid_out(valid1), .fifo_count(count1), .Fifo_full(full1),
        .fifo_empty(empty1), .almost_full(af1), .almost_empty(ae1), .fifo_pause(pause1),
        .fifo_error(err1));

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid pop must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset && valid0) begin
            if (exp_q.size() == 0)
                chk("unexpected_pop", 1, 0);
            else
                chk("pop_data", int'(dout0), int'(exp_q.pop_front()));
        end
    end

    // One cycle of stimulus on the registered instance; scoreboard updated at issue.
    task automatic step(input logic w, input logic r, input logic [9:0] d);
        bit pop_ok, push_ok;
        write0 = w; read0 = r; din0 = d;
        pop_ok  = r && (mdl.size() > 0);
        push_ok = w && ((mdl.size() < 8) || pop_ok);
        if (pop_ok)  exp_q.push_back(mdl.pop_front());
        if (push_ok) mdl.push_back(d);
        @(posedge clk); #1;
        write0 = 1'b0; read0 = 1'b0; err_clr = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step(1'b0, 1'b0, 10'h0);
        chk("err_clr", int'(err0), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, int'(count0), 0);
        chk({tag, "_empty"}, int'(empty0), 1);
        chk({tag, "_full"},  int'(full0), 0);
        chk({tag, "_af"},    int'(af0), 0);
        chk({tag, "_ae"},    int'(ae0), 1);
        chk({tag, "_pause"}, int'(pause0), 0);
        chk({tag, "_err"},   int'(err0), 0);
        chk({tag, "_valid"}, int'(valid0), 0);
        chk({tag, "_dout"},  int'(dout0), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        chk_reset_vals("rst");
        chk("rst_fwft_valid", int'(valid1), 0);
        #11 reset = 1'b1;
        @(posedge clk); #1;

        // 1: fill; almost_full/pause rise at count 6, full at 8, then overflow
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 10'(i));
            chk("fill_count", int'(count0), i);
            chk("fill_af",    int'(af0),    (i >= 6) ? 1 : 0);
            chk("fill_pause", int'(pause0), (i >= 6) ? 1 : 0);
            chk("fill_full",  int'(full0),  (i == 8) ? 1 : 0);
        end
        step(1'b1, 1'b0, 10'h3FF);
        chk("ovf_err",   int'(err0),   1);
        chk("ovf_count", int'(count0), 8);
        clear_err();

        // 2: drain; data checked by the monitor, pause drops and almost_empty rises at count 2
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 10'h0);
            chk("drain_count", int'(count0), 8 - k);
            chk("drain_pause", int'(pause0), (8 - k > 2) ? 1 : 0);
            chk("drain_ae",    int'(ae0),    (8 - k <= 2) ? 1 : 0);
        end
        step(1'b0, 1'b1, 10'h0);
        chk("udf_err",   int'(err0),   1);
        chk("udf_hold",  int'(dout0),  10'h008);
        chk("udf_valid", int'(valid0), 0);
        clear_err();

        // 3: simultaneous read+write when full, then when empty
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'(10'h010 + i));
        step(1'b1, 1'b1, 10'h0AA);
        chk("full_rw_count", int'(count0), 8);
        chk("full_rw_err",   int'(err0),   0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 10'h0);
        chk("drained_empty", int'(empty0), 1);
        step(1'b1, 1'b1, 10'h0BB);
        chk("empty_rw_err",   int'(err0),   1);
        chk("empty_rw_count", int'(count0), 1);
        step(1'b0, 1'b1, 10'h0);
        chk("empty_rw_after", int'(count0), 0);
        clear_err();

        // 4: random traffic with occupancy held in 1..7, pointers wrap repeatedly
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'(10'h100 + i));
        for (int i = 0; i < 24; i++) begin
            logic w, r;
            int   sz;
            w = 1'($urandom_range(1, 0));
            r = 1'($urandom_range(1, 0));
            sz = mdl.size();
            if (sz + int'(w) - int'(r) > 7) w = 1'b0;
            if (sz + int'(w) - int'(r) < 1) r = 1'b0;
            step(w, r, 10'($urandom_range(1023, 0)));
            chk("wrap_count", int'(count0), mdl.size());
        end
        while (mdl.size() > 0) step(1'b0, 1'b1, 10'h0);
        step(1'b0, 1'b0, 10'h0);
        chk("wrap_err", int'(err0), 0);

        // 5: FWFT head word visible without a read, valid drops once emptied
        write1 = 1'b1; din1 = 10'h155;
        @(posedge clk); #1;
        write1 = 1'b0;
        chk("fwft_data",  int'(dout1),  10'h155);
        chk("fwft_valid", int'(valid1), 1);
        read1 = 1'b1;
        @(posedge clk); #1;
        read1 = 1'b0;
        chk("fwft_valid_off", int'(valid1), 0);
        chk("fwft_empty",     int'(empty1), 1);

        // 6: async reset mid-cycle at count 5 with error set
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'(10'h200 + i));
        step(1'b1, 1'b0, 10'h2FF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'h0);
        step(1'b0, 1'b0, 10'h0);
        chk("pre_rst_count", int'(count0), 5);
        chk("pre_rst_err",   int'(err0),   1);
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("arst");
        mdl.delete();
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_count", int'(count0), 0);

        step(1'b0, 1'b0, 10'h0);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
